// File: rtl/xgriscv_pipe_controller.sv
// Pipelined RV32I control: ID decode, ID/EX, EX/MEM, MEM/WB control registers, hazard stalls and IF/ID flush.
// Optional multiply/divide support is enabled by defining XGRISCV_MDU_EN.
module xgriscv_pipe_controller #(
    parameter int RFIDX_WIDTH   = 5,
    parameter int ALUCTRL_WIDTH = 4,
    parameter int MDU_LATENCY   = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     id_valid,
    input  logic [6:0]               opcode,
    input  logic [2:0]               funct3,
    input  logic [6:0]               funct7,
    input  logic [RFIDX_WIDTH-1:0]   rd,
    input  logic [RFIDX_WIDTH-1:0]   rs1,
    input  logic [RFIDX_WIDTH-1:0]   rs2,
    input  logic                     zero,
    input  logic                     lt,
    output logic [4:0]               immctrl,
    output logic                     bunsigned,
    output logic                     pcsrc,
    output logic                     jalr,
    output logic                     stall,
    output logic                     flush_ifid,
    output logic [ALUCTRL_WIDTH-1:0] ex_aluctrl,
    output logic [1:0]               ex_alusrca,
    output logic [1:0]               ex_alusrcb,
    output logic [RFIDX_WIDTH-1:0]   ex_rd,
    output logic                     mem_memwrite,
    output logic [1:0]               mem_swhb,
    output logic [1:0]               mem_lwhb,
    output logic                     mem_lunsigned,
    output logic [RFIDX_WIDTH-1:0]   mem_rd,
    output logic                     wb_memtoreg,
    output logic                     wb_regwrite,
    output logic [RFIDX_WIDTH-1:0]   wb_rd
);
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [ALUCTRL_WIDTH-1:0] ALU_CTRL_ZERO = ALUCTRL_WIDTH'(4'd0);
    localparam logic [ALUCTRL_WIDTH-1:0] ALU_CTRL_ADD  = ALUCTRL_WIDTH'(4'd1);

    typedef struct packed {
        logic [ALUCTRL_WIDTH-1:0] aluctrl;
        logic [1:0]               srca;
        logic [1:0]               srcb;
        logic [RFIDX_WIDTH-1:0]   rd;
        logic                     regwrite;
        logic                     memtoreg;
        logic                     memwrite;
        logic [1:0]               swhb;
        logic [1:0]               lwhb;
        logic                     lunsigned;
    } ctrl_t;

    localparam ctrl_t CTRL_BUBBLE = '0;

    if (MDU_LATENCY < 1) begin : g_bad_latency
        $error("MDU_LATENCY must be at least 1");
    end

    // Base ALU codes: ZERO=0, ADD=1, SUB=2, SLL=3, SLT=4, SLTU=5, XOR=6, SRL=7, SRA=8, OR=9, AND=10
    function automatic logic [ALUCTRL_WIDTH-1:0] alu_of_f3(input logic [2:0] f3, input logic alt);
        logic [3:0] code;
        case (f3)
            3'b000:  code = alt ? 4'd2 : 4'd1;
            3'b001:  code = 4'd3;
            3'b010:  code = 4'd4;
            3'b011:  code = 4'd5;
            3'b100:  code = 4'd6;
            3'b101:  code = alt ? 4'd8 : 4'd7;
            3'b110:  code = 4'd9;
            3'b111:  code = 4'd10;
            default: code = 4'd0;
        endcase
        return ALUCTRL_WIDTH'(code);
    endfunction

    ctrl_t       dec_s;
    ctrl_t       ex_r;
    logic        legal_s, rd_wr_s, reads_rs1_s, reads_rs2_s, mdu_op_s;
    logic        is_jal_s, is_jalr_s, is_branch_s, taken_s, id_ok_s;
    logic [4:0]  imm_s;
    logic        rs1_live_s, rs2_live_s, h1_s, h2_s, mdu_busy_s;
    logic        mem_memtoreg_r, mem_regwrite_r;

    // ID decode of the instruction fields into a control bundle and class flags
    always_comb begin
        dec_s       = CTRL_BUBBLE;
        legal_s     = 1'b0;
        rd_wr_s     = 1'b0;
        reads_rs1_s = 1'b0;
        reads_rs2_s = 1'b0;
        mdu_op_s    = 1'b0;
        is_jal_s    = 1'b0;
        is_jalr_s   = 1'b0;
        is_branch_s = 1'b0;
        imm_s       = 5'b00000;
        case (opcode)
            OPC_LUI: begin
                legal_s = 1'b1; rd_wr_s = 1'b1; imm_s = 5'b00010;
                dec_s.srca = 2'b01; dec_s.srcb = 2'b01; dec_s.aluctrl = ALU_CTRL_ADD;
            end
            OPC_AUIPC: begin
                legal_s = 1'b1; rd_wr_s = 1'b1; imm_s = 5'b00010;
                dec_s.srca = 2'b10; dec_s.srcb = 2'b01; dec_s.aluctrl = ALU_CTRL_ADD;
            end
            OPC_JAL: begin
                legal_s = 1'b1; rd_wr_s = 1'b1; is_jal_s = 1'b1; imm_s = 5'b00001;
                dec_s.srca = 2'b10; dec_s.srcb = 2'b10; dec_s.aluctrl = ALU_CTRL_ADD;
            end
            OPC_JALR: begin
                legal_s = (funct3 == 3'b000); rd_wr_s = 1'b1; is_jalr_s = 1'b1;
                reads_rs1_s = 1'b1; imm_s = 5'b10000;
                dec_s.srca = 2'b10; dec_s.srcb = 2'b10; dec_s.aluctrl = ALU_CTRL_ADD;
            end
            OPC_BRANCH: begin
                legal_s = (funct3 != 3'b010) && (funct3 != 3'b011);
                is_branch_s = 1'b1; reads_rs1_s = 1'b1; reads_rs2_s = 1'b1; imm_s = 5'b00100;
            end
            OPC_LOAD: begin
                legal_s = 1'b1; rd_wr_s = 1'b1; reads_rs1_s = 1'b1; imm_s = 5'b10000;
                dec_s.srcb = 2'b01; dec_s.aluctrl = ALU_CTRL_ADD; dec_s.memtoreg = 1'b1;
                case (funct3)
                    3'b000:  dec_s.lwhb = 2'b10;
                    3'b001:  dec_s.lwhb = 2'b01;
                    3'b010:  dec_s.lwhb = 2'b00;
                    3'b100:  begin dec_s.lwhb = 2'b10; dec_s.lunsigned = 1'b1; end
                    3'b101:  begin dec_s.lwhb = 2'b01; dec_s.lunsigned = 1'b1; end
                    default: legal_s = 1'b0;
                endcase
            end
            OPC_STORE: begin
                legal_s = 1'b1; reads_rs1_s = 1'b1; reads_rs2_s = 1'b1; imm_s = 5'b01000;
                dec_s.srcb = 2'b01; dec_s.aluctrl = ALU_CTRL_ADD; dec_s.memwrite = 1'b1;
                case (funct3)
                    3'b000:  dec_s.swhb = 2'b11;
                    3'b001:  dec_s.swhb = 2'b10;
                    3'b010:  dec_s.swhb = 2'b01;
                    default: legal_s = 1'b0;
                endcase
            end
            OPC_OPIMM: begin
                rd_wr_s = 1'b1; reads_rs1_s = 1'b1; imm_s = 5'b10000; dec_s.srcb = 2'b01;
                dec_s.aluctrl = alu_of_f3(funct3, (funct3 == 3'b101) && funct7[5]);
                case (funct3)
                    3'b001:  legal_s = (funct7 == 7'b0000000);
                    3'b101:  legal_s = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
                    default: legal_s = 1'b1;
                endcase
            end
            OPC_OP: begin
                rd_wr_s = 1'b1; reads_rs1_s = 1'b1; reads_rs2_s = 1'b1;
                dec_s.aluctrl = alu_of_f3(funct3, funct7[5]);
                case (funct7)
                    7'b0000000: legal_s = 1'b1;
                    7'b0100000: legal_s = (funct3 == 3'b000) || (funct3 == 3'b101);
`ifdef XGRISCV_MDU_EN
                    7'b0000001: begin
                        legal_s = 1'b1; mdu_op_s = 1'b1;
                        dec_s.aluctrl = ALUCTRL_WIDTH'({1'b1, funct3});
                    end
`endif
                    default:    legal_s = 1'b0;
                endcase
            end
            default: legal_s = 1'b0;
        endcase
        if (id_valid && legal_s) begin
            dec_s.regwrite = rd_wr_s && (rd != '0);
            dec_s.rd       = dec_s.regwrite ? rd : '0;
        end else begin
            dec_s = CTRL_BUBBLE;
        end
    end

    // Branch condition from the ID comparator
    always_comb begin
        taken_s = 1'b0;
        case (funct3)
            3'b000:          taken_s = zero;
            3'b001:          taken_s = !zero;
            3'b100, 3'b110:  taken_s = lt;
            3'b101, 3'b111:  taken_s = !lt;
            default:         taken_s = 1'b0;
        endcase
    end

    assign id_ok_s    = id_valid && legal_s;
    assign rs1_live_s = id_ok_s && reads_rs1_s && (rs1 != '0);
    assign rs2_live_s = id_ok_s && reads_rs2_s && (rs2 != '0);

    // Load-use: the value only exists after MEM, so any reader must wait a cycle
    assign h1_s = ex_r.memtoreg && (ex_r.rd != '0) &&
                  ((rs1_live_s && (rs1 == ex_r.rd)) || (rs2_live_s && (rs2 == ex_r.rd)));
    // The ID comparator and JALR target cannot take forwarded EX results or in-flight load data
    assign h2_s = (is_branch_s || is_jalr_s) &&
                  ((ex_r.regwrite && ((rs1_live_s && (rs1 == ex_r.rd)) || (rs2_live_s && (rs2 == ex_r.rd)))) ||
                   (mem_memtoreg_r && ((rs1_live_s && (rs1 == mem_rd)) || (rs2_live_s && (rs2 == mem_rd)))));

    assign stall      = h1_s || h2_s || mdu_busy_s;
    assign pcsrc      = id_ok_s && !stall && (is_jal_s || is_jalr_s || (is_branch_s && taken_s));
    assign flush_ifid = pcsrc;
    assign jalr       = id_ok_s && is_jalr_s;
    assign bunsigned  = id_ok_s && is_branch_s && funct3[1];
    assign immctrl    = id_ok_s ? imm_s : 5'b00000;

`ifdef XGRISCV_MDU_EN
    localparam int CNT_W = (MDU_LATENCY < 2) ? 1 : $clog2(MDU_LATENCY + 1);
    logic [CNT_W-1:0] mdu_cnt_r;
    logic             mdu_hold_s;

    assign mdu_busy_s = (mdu_cnt_r != '0);
    assign mdu_hold_s = (mdu_cnt_r > CNT_W'(1'b1));

    // Counts the remaining EX cycles of a multiply/divide
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mdu_cnt_r <= '0;
        end else if (mdu_busy_s) begin
            mdu_cnt_r <= mdu_cnt_r - CNT_W'(1'b1);
        end else if (!stall && id_ok_s && mdu_op_s) begin
            mdu_cnt_r <= CNT_W'(MDU_LATENCY);
        end else begin
            mdu_cnt_r <= '0;
        end
    end
`else
    logic unused_mdu_s;
    assign unused_mdu_s = mdu_op_s;
    assign mdu_busy_s   = 1'b0;
`endif

    // ID/EX register: bubble on stall, held while a multi-cycle op occupies EX
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ex_r <= CTRL_BUBBLE;
`ifdef XGRISCV_MDU_EN
        end else if (mdu_hold_s) begin
            ex_r <= ex_r;
`endif
        end else if (stall) begin
            ex_r <= CTRL_BUBBLE;
        end else begin
            ex_r <= dec_s;
        end
    end

    // EX/MEM register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_memwrite <= 1'b0; mem_swhb <= 2'b00; mem_lwhb <= 2'b00; mem_lunsigned <= 1'b0;
            mem_rd <= '0; mem_memtoreg_r <= 1'b0; mem_regwrite_r <= 1'b0;
`ifdef XGRISCV_MDU_EN
        end else if (mdu_hold_s) begin
            mem_memwrite <= 1'b0; mem_swhb <= 2'b00; mem_lwhb <= 2'b00; mem_lunsigned <= 1'b0;
            mem_rd <= '0; mem_memtoreg_r <= 1'b0; mem_regwrite_r <= 1'b0;
`endif
        end else begin
            mem_memwrite <= ex_r.memwrite; mem_swhb <= ex_r.swhb; mem_lwhb <= ex_r.lwhb;
            mem_lunsigned <= ex_r.lunsigned; mem_rd <= ex_r.rd;
            mem_memtoreg_r <= ex_r.memtoreg; mem_regwrite_r <= ex_r.regwrite;
        end
    end

    // MEM/WB register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wb_memtoreg <= 1'b0; wb_regwrite <= 1'b0; wb_rd <= '0;
        end else begin
            wb_memtoreg <= mem_memtoreg_r; wb_regwrite <= mem_regwrite_r; wb_rd <= mem_rd;
        end
    end

    assign ex_aluctrl = ex_r.aluctrl;
    assign ex_alusrca = ex_r.srca;
    assign ex_alusrcb = ex_r.srcb;
    assign ex_rd      = ex_r.rd;
endmodule
